// File: rtl/out_port_tx_if.sv
// out_port_tx_if: CPU output-port write strobe and data, overflow clear, serial line and status byte.
interface out_port_tx_if;
  logic [7:0] out_data;
  logic       out_wr;
  logic       clr_ovf;
  logic       tx;
  logic [7:0] stat;
  modport master(output out_data, out_wr, clr_ovf, input tx, stat);
  modport slave(input out_data, out_wr, clr_ovf, output tx, stat);
endinterface

// File: rtl/out_port_tx.sv
// out_port_tx: 4-deep FIFO feeding an async serial transmitter; define OUT_PORT_TX_PARITY_EN for an even-parity bit.
module out_port_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic          clk,
  input logic          rst,
  out_port_tx_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef OUT_PORT_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);
  state_t     state;
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count, count_nxt, bidx;
  logic [7:0] baud, shift, stat_r;
  logic       tx_r, ovf, ovf_nxt, busy_nxt, bnd, pop, wr_ok;
`ifdef OUT_PORT_TX_PARITY_EN
  logic       par;
`endif
  assign bus.tx = tx_r;
  assign bus.stat = stat_r;
  always_comb begin
    bnd = baud == 8'd0;
    pop = count != 3'd0 && (state == IDLE || (state == STOP && bnd));
    wr_ok = bus.out_wr && (count != 3'd4 || pop);
    count_nxt = count + {2'b0, wr_ok} - {2'b0, pop};
    ovf_nxt = (bus.out_wr && !wr_ok) || (ovf && !bus.clr_ovf);
    busy_nxt = pop || (state != IDLE && !(state == STOP && bnd));
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= bus.out_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      bidx <= '0;
      baud <= '0;
      shift <= '0;
      tx_r <= 1'b1;
      ovf <= 1'b0;
      stat_r <= 8'h10;
`ifdef OUT_PORT_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      count <= count_nxt;
      ovf <= ovf_nxt;
      stat_r <= {ovf_nxt, busy_nxt, count_nxt == 3'd4, count_nxt == 3'd0, 1'b0, count_nxt};
      if (wr_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        shift <= mem[rd_ptr];
        state <= START;
        tx_r <= 1'b0;
        baud <= RELOAD;
`ifdef OUT_PORT_TX_PARITY_EN
        par <= ^mem[rd_ptr];
`endif
      end else if (state != IDLE) begin
        if (!bnd) baud <= baud - 8'd1;
        else begin
          baud <= RELOAD;
          case (state)
            START: begin
              state <= DATA;
              bidx <= '0;
              tx_r <= shift[0];
            end
            DATA: if (bidx == 3'd7) begin
`ifdef OUT_PORT_TX_PARITY_EN
              state <= PARITY;
              tx_r <= par;
`else
              state <= STOP;
              tx_r <= 1'b1;
`endif
            end else begin
              shift <= shift >> 1;
              tx_r <= shift[1];
              bidx <= bidx + 3'd1;
            end
`ifdef OUT_PORT_TX_PARITY_EN
            PARITY: begin
              state <= STOP;
              tx_r <= 1'b1;
            end
`endif
            default: begin
              state <= IDLE;
              tx_r <= 1'b1;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_out_port_tx.sv
// tb_out_port_tx: frame-level reference model plus serial-line scoreboard for out_port_tx.
module tb_out_port_tx;
  localparam int C = 4;
`ifdef OUT_PORT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * C;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  out_port_tx_if bus();
  out_port_tx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  bit         busy_m = 0;
  bit         ovf_m = 0;
  int         rem = 0;
  logic [7:0] cur = 8'h00;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic exp_tx_f();
    int i;
    if (!busy_m) return 1'b1;
    i = (F - rem) / C;
    if (i == 0) return 1'b0;
    if (i <= 8) return cur[i-1];
`ifdef OUT_PORT_TX_PARITY_EN
    if (i == 9) return ^cur;
`endif
    return 1'b1;
  endfunction
  function automatic logic [7:0] exp_stat_f();
    return {ovf_m, busy_m, q.size() == 4, q.size() == 0, 1'b0, 3'(q.size())};
  endfunction
  // Reference: a frame occupies F cycles; the next pop happens on the frame's last edge.
  initial begin
    bit pop, acc;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        exp_q.delete();
        busy_m = 0;
        ovf_m = 0;
        rem = 0;
      end else begin
        pop = q.size() > 0 && (!busy_m || rem == 1);
        acc = bus.out_wr && (q.size() < 4 || pop);
        if (pop) begin
          cur = q.pop_front();
          busy_m = 1;
          rem = F;
        end else if (busy_m) begin
          rem--;
          if (rem == 0) busy_m = 0;
        end
        if (acc) begin
          q.push_back(bus.out_data);
          exp_q.push_back(bus.out_data);
        end
        ovf_m = (bus.out_wr && !acc) || (ovf_m && !bus.clr_ovf);
      end
    end
  end
  initial begin
    bit          mact = 0;
    int          mt = 0;
    logic [10:0] mbits = '0;
    logic [7:0]  e;
    forever begin
      @(posedge clk);
      #1;
      chk("tx", bus.tx, exp_tx_f());
      chk("stat", bus.stat, exp_stat_f());
      if (!rst) mact = 0;
      else begin
        if (!mact && bus.tx === 1'b0) begin
          mact = 1;
          mt = 0;
        end
        if (mact) begin
          if (mt % C == C / 2) begin
            mbits[mt/C] = bus.tx;
            if (mt / C == NB - 1) begin
              mact = 0;
              chk("frame_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame_data", mbits[8:1], e);
                chk("start_bit", mbits[0], 0);
                chk("stop_bit", mbits[NB-1], 1);
`ifdef OUT_PORT_TX_PARITY_EN
                chk("parity_bit", mbits[9], ^e);
`endif
              end
            end
          end
          mt++;
        end
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(logic [7:0] d);
    bus.out_data = d;
    bus.out_wr = 1'b1;
    @(negedge clk);
    bus.out_wr = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((busy_m || q.size() > 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 5000, 1);
  endtask
  initial begin
    int n;
    bus.out_data = 8'h00;
    bus.out_wr = 1'b0;
    bus.clr_ovf = 1'b0;
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    #1;
    chk("reset_tx", bus.tx, 1);
    chk("reset_stat", bus.stat, 8'h10);
    cyc(100);
    wr(8'hA5);
    drain();
    cyc(5);
    for (int i = 1; i <= 6; i++) wr(8'(i));
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    n = 0;
    while (!(busy_m && rem == 1 && q.size() == 4) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("full_pop_wait", n < 1000, 1);
    wr(8'h07);
    drain();
    wr(8'h03);
    drain();
    cyc(3);
    wr(8'h3C);
    wr(8'hC3);
    wr(8'h5A);
    n = 0;
    while (!(busy_m && (F - rem) / C == 4 && q.size() == 2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_frame_wait", n < 1000, 1);
    rst = 1'b0;
    #1;
    chk("abort_tx", bus.tx, 1);
    chk("abort_stat", bus.stat, 8'h10);
    cyc(3);
    rst = 1'b1;
    cyc(100);
    repeat (400) begin
      bus.out_data = 8'($urandom);
      bus.out_wr = $urandom_range(0, 3) == 0;
      bus.clr_ovf = $urandom_range(0, 15) == 0;
      @(negedge clk);
    end
    bus.out_wr = 1'b0;
    bus.clr_ovf = 1'b0;
    drain();
    cyc(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
